// File: rtl/spi_target_pkg.sv
// Shared types and constants for the SPI target: FSM state encoding and byte type.
package spi_target_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StLoad,
    StShift
  } spi_target_state_e;

  localparam int unsigned SpiFrameBits = 8;

  typedef logic [7:0] spi_byte_t;

endpackage

// File: rtl/spi_target_fifo.sv
// Synchronous FIFO with valid/ready on both sides and an occupancy output.
// A push is accepted while full if a pop happens in the same cycle.
module spi_target_fifo #(
  parameter int unsigned Depth = 8,
  parameter int unsigned Width = 8
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic [Width-1:0]        in_data_i,
  input  logic                    in_valid_i,
  output logic                    in_ready_o,
  output logic [Width-1:0]        out_data_o,
  output logic                    out_valid_o,
  input  logic                    out_ready_i,
  output logic [$clog2(Depth):0]  level_o
);

  localparam int unsigned AW = $clog2(Depth);

  logic [Width-1:0] mem_q [Depth];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      count_q;
  logic             push, pop;

  assign out_valid_o = (count_q != '0);
  assign pop         = out_valid_o && out_ready_i;
  assign in_ready_o  = (count_q != (AW+1)'(Depth)) || pop;
  assign push        = in_valid_i && in_ready_o;
  assign out_data_o  = mem_q[rd_ptr_q];
  assign level_o     = count_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      unique case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) mem_q[wr_ptr_q] <= in_data_i;
  end

endmodule

// File: rtl/spi_target.sv
// SPI mode-0 target with oversampled pins and TX/RX byte FIFOs.
// Optional macro SPI_TARGET_LSB_FIRST_EN adds lsb_first_i for per-byte LSB-first shifting.
module spi_target
  import spi_target_pkg::*;
#(
  parameter int unsigned FifoDepth  = 8,
  parameter spi_byte_t   TxIdleByte = 8'hFF
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic                        spi_sck_i,
  input  logic                        spi_cs_ni,
  input  logic                        spi_copi_i,
  output logic                        spi_cipo_o,
  output logic                        spi_cipo_en_o,
  input  logic [7:0]                  tx_data_i,
  input  logic                        tx_valid_i,
  output logic                        tx_ready_o,
  output logic [7:0]                  rx_data_o,
  output logic                        rx_valid_o,
  input  logic                        rx_ready_i,
`ifdef SPI_TARGET_LSB_FIRST_EN
  input  logic                        lsb_first_i,
`endif
  output logic [$clog2(FifoDepth):0]  tx_level_o,
  output logic [$clog2(FifoDepth):0]  rx_level_o,
  output logic                        busy_o,
  output logic                        rx_overflow_o,
  output logic                        tx_underflow_o,
  output logic                        frame_abort_o
);

  // [0] and [1] are the synchroniser, [2] is the edge-detect delay
  logic [2:0] sck_q, cs_q;
  logic [1:0] copi_q;
  logic       sck_rise, sck_fall, cs_rise, cs_fall;
  logic [1:0] warm_q;
  logic       armed_q;

  spi_target_state_e state_q, state_d;
  logic [3:0] bit_cnt_q, bit_cnt_d;
  spi_byte_t  rx_shift_q, rx_shift_d;
  spi_byte_t  tx_shift_q, tx_shift_d;
  spi_byte_t  rx_byte_q, rx_byte_d;
  logic       rx_push_q, rx_push_d;
  logic       cipo_q, cipo_d;
  logic       lsb_q, lsb_d;
  logic       lsb_sel, do_load;

  logic       tx_out_valid, tx_pop, rx_in_ready;
  spi_byte_t  tx_out_data, load_byte;

`ifdef SPI_TARGET_LSB_FIRST_EN
  assign lsb_sel = lsb_first_i;
`else
  assign lsb_sel = 1'b0;
`endif

  assign sck_rise = sck_q[1] & ~sck_q[2];
  assign sck_fall = ~sck_q[1] & sck_q[2];
  assign cs_rise  = cs_q[1] & ~cs_q[2];
  assign cs_fall  = ~cs_q[1] & cs_q[2];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sck_q   <= '0;
      cs_q    <= '1;
      copi_q  <= '0;
      warm_q  <= '0;
      armed_q <= 1'b0;
    end else begin
      sck_q  <= {sck_q[1:0], spi_sck_i};
      cs_q   <= {cs_q[1:0], spi_cs_ni};
      copi_q <= {copi_q[0], spi_copi_i};
      if (warm_q != 2'd3) warm_q <= warm_q + 2'd1;
      // The CS reset value fakes a fall if the pin is low; wait for a genuine high level
      armed_q <= armed_q | ((warm_q == 2'd3) && cs_q[1]);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= StIdle;
      bit_cnt_q  <= '0;
      rx_shift_q <= '0;
      tx_shift_q <= '0;
      rx_byte_q  <= '0;
      rx_push_q  <= 1'b0;
      cipo_q     <= 1'b0;
      lsb_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      rx_shift_q <= rx_shift_d;
      tx_shift_q <= tx_shift_d;
      rx_byte_q  <= rx_byte_d;
      rx_push_q  <= rx_push_d;
      cipo_q     <= cipo_d;
      lsb_q      <= lsb_d;
    end
  end

  assign load_byte = tx_out_valid ? tx_out_data : TxIdleByte;

  always_comb begin
    state_d       = state_q;
    bit_cnt_d     = bit_cnt_q;
    rx_shift_d    = rx_shift_q;
    tx_shift_d    = tx_shift_q;
    rx_byte_d     = rx_byte_q;
    rx_push_d     = 1'b0;
    cipo_d        = cipo_q;
    lsb_d         = lsb_q;
    do_load       = 1'b0;
    frame_abort_o = 1'b0;
    if (cs_rise) begin
      state_d       = StIdle;
      bit_cnt_d     = '0;
      frame_abort_o = (state_q == StShift) && (bit_cnt_q != '0) &&
                      (bit_cnt_q < 4'(SpiFrameBits));
    end else begin
      unique case (state_q)
        StIdle: if (cs_fall && armed_q) state_d = StLoad;
        StLoad: begin
          do_load = 1'b1;
          state_d = StShift;
        end
        StShift: begin
          if (sck_rise && (bit_cnt_q < 4'(SpiFrameBits))) begin
            rx_shift_d = lsb_q ? {copi_q[1], rx_shift_q[7:1]} : {rx_shift_q[6:0], copi_q[1]};
            bit_cnt_d  = bit_cnt_q + 4'd1;
            if (bit_cnt_q == 4'(SpiFrameBits - 1)) begin
              rx_push_d = 1'b1;
              rx_byte_d = rx_shift_d;
            end
          end else if (sck_fall) begin
            if (bit_cnt_q == 4'(SpiFrameBits)) begin
              do_load = 1'b1;
            end else if (bit_cnt_q != '0) begin
              cipo_d     = lsb_q ? tx_shift_q[0] : tx_shift_q[7];
              tx_shift_d = lsb_q ? {1'b0, tx_shift_q[7:1]} : {tx_shift_q[6:0], 1'b0};
            end
          end
        end
        default: state_d = StIdle;
      endcase
    end
    if (do_load) begin
      lsb_d      = lsb_sel;
      cipo_d     = lsb_sel ? load_byte[0] : load_byte[7];
      tx_shift_d = lsb_sel ? {1'b0, load_byte[7:1]} : {load_byte[6:0], 1'b0};
      bit_cnt_d  = '0;
    end
  end

  assign tx_pop         = do_load && tx_out_valid;
  assign tx_underflow_o = do_load && !tx_out_valid;
  assign rx_overflow_o  = rx_push_q && !rx_in_ready;
  assign busy_o         = ~cs_q[1];
  assign spi_cipo_en_o  = busy_o;
  assign spi_cipo_o     = cipo_q;

  spi_target_fifo #(
    .Depth (FifoDepth),
    .Width (8)
  ) u_tx_fifo (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .in_data_i   (tx_data_i),
    .in_valid_i  (tx_valid_i),
    .in_ready_o  (tx_ready_o),
    .out_data_o  (tx_out_data),
    .out_valid_o (tx_out_valid),
    .out_ready_i (tx_pop),
    .level_o     (tx_level_o)
  );

  spi_target_fifo #(
    .Depth (FifoDepth),
    .Width (8)
  ) u_rx_fifo (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .in_data_i   (rx_byte_q),
    .in_valid_i  (rx_push_q),
    .in_ready_o  (rx_in_ready),
    .out_data_o  (rx_data_o),
    .out_valid_o (rx_valid_o),
    .out_ready_i (rx_ready_i),
    .level_o     (rx_level_o)
  );

endmodule

// File: tb/tb_spi_target.sv
// Directed bench for spi_target: host drives SCK at clk/8, mode 0, default build.
module tb_spi_target;

  logic       clk = 1'b0;
  logic       rst;
  logic       sck, cs_n, copi;
  logic       cipo, cipo_en;
  logic [7:0] tx_data;
  logic       tx_valid, tx_ready;
  logic [7:0] rx_data;
  logic       rx_valid, rx_ready;
  logic [3:0] tx_level, rx_level;
  logic       busy, rx_ovf, tx_ufl, f_abort;

  int checks   = 0;
  int failures = 0;
  int n_ufl    = 0;
  int n_ovf    = 0;
  int n_abort  = 0;

  always #5 clk = ~clk;

  spi_target #(
    .FifoDepth  (8),
    .TxIdleByte (8'hFF)
  ) dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .spi_sck_i      (sck),
    .spi_cs_ni      (cs_n),
    .spi_copi_i     (copi),
    .spi_cipo_o     (cipo),
    .spi_cipo_en_o  (cipo_en),
    .tx_data_i      (tx_data),
    .tx_valid_i     (tx_valid),
    .tx_ready_o     (tx_ready),
    .rx_data_o      (rx_data),
    .rx_valid_o     (rx_valid),
    .rx_ready_i     (rx_ready),
    .tx_level_o     (tx_level),
    .rx_level_o     (rx_level),
    .busy_o         (busy),
    .rx_overflow_o  (rx_ovf),
    .tx_underflow_o (tx_ufl),
    .frame_abort_o  (f_abort)
  );

  always @(posedge clk) begin
    if (tx_ufl)  n_ufl++;
    if (rx_ovf)  n_ovf++;
    if (f_abort) n_abort++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cs_start();
    @(negedge clk);
    cs_n = 1'b0;
    repeat (6) @(negedge clk);
  endtask

  task automatic cs_end();
    sck = 1'b0;
    repeat (4) @(negedge clk);
    cs_n = 1'b1;
    repeat (6) @(negedge clk);
  endtask

  // Leaves SCK high after the last bit; the next byte (or cs_end) supplies the fall
  task automatic xfer(input logic [7:0] mo, input int unsigned nbits, input bit chk_lat,
                      output logic [7:0] mi, output int lat);
    mi  = '0;
    lat = 0;
    for (int unsigned i = 0; i < nbits; i++) begin
      sck  = 1'b0;
      copi = mo[7-i];
      repeat (4) @(negedge clk);
      mi  = {mi[6:0], cipo};
      sck = 1'b1;
      if (chk_lat && (i == nbits - 1)) begin
        for (int k = 1; k <= 4; k++) begin
          @(posedge clk);
          #1;
          if (lat == 0 && rx_valid) lat = k;
        end
        @(negedge clk);
      end else begin
        repeat (4) @(negedge clk);
      end
    end
  endtask

  task automatic push_tx(input logic [7:0] b);
    tx_data  = b;
    tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
  endtask

  task automatic drain_rx();
    for (int k = 0; k < 16 && rx_valid; k++) begin
      rx_ready = 1'b1;
      @(negedge clk);
      rx_ready = 1'b0;
    end
  endtask

  initial begin
    logic [7:0] mi, mi2, mi3;
    int lat, base;
    rst = 1'b1; sck = 1'b0; cs_n = 1'b1; copi = 1'b0;
    tx_data = '0; tx_valid = 1'b0; rx_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_cipo", cipo, 0);
    chk("rst_cipo_en", cipo_en, 0);
    chk("rst_tx_ready", tx_ready, 1);
    chk("rst_rx_valid", rx_valid, 0);
    chk("rst_busy", busy, 0);
    rst = 1'b0;
    repeat (6) @(negedge clk);

    // 1: single byte exchange with latency check
    push_tx(8'hA5);
    chk("t1_tx_level", tx_level, 1);
    cs_start();
    chk("t1_busy", busy, 1);
    chk("t1_cipo_en", cipo_en, 1);
    xfer(8'h3C, 8, 1'b1, mi, lat);
    chk("t1_host_rx", mi, 8'hA5);
    chk("t1_rx_lat_ok", (lat >= 1 && lat <= 4), 1);
    chk("t1_rx_data", rx_data, 8'h3C);
    chk("t1_tx_level", tx_level, 0);
    cs_end();
    chk("t1_busy_end", busy, 0);
    drain_rx();
    chk("t1_rx_level", rx_level, 0);

    // 2: empty TX, two bytes
    base = n_ufl;
    cs_start();
    xfer(8'h12, 8, 1'b0, mi, lat);
    xfer(8'h34, 8, 1'b0, mi2, lat);
    chk("t2_host_rx0", mi, 8'hFF);
    chk("t2_host_rx1", mi2, 8'hFF);
    chk("t2_ufl_pulses", n_ufl - base, 2);
    cs_end();
    chk("t2_rx_level", rx_level, 2);
    drain_rx();

    // 3: RX overflow with 10 bytes into 8 entries
    base = n_ovf;
    cs_start();
    for (int i = 0; i < 10; i++) xfer(8'(i), 8, 1'b0, mi, lat);
    chk("t3_rx_level", rx_level, 8);
    chk("t3_ovf_pulses", n_ovf - base, 2);
    cs_end();
    for (int i = 0; i < 8; i++) begin
      chk("t3_pop_data", rx_data, i);
      rx_ready = 1'b1;
      @(negedge clk);
      rx_ready = 1'b0;
    end
    chk("t3_rx_empty", rx_valid, 0);

    // 4: aborted partial byte then a full one
    base = n_abort;
    cs_start();
    xfer(8'hFF, 5, 1'b0, mi, lat);
    cs_end();
    chk("t4_abort_pulses", n_abort - base, 1);
    chk("t4_rx_level_abort", rx_level, 0);
    cs_start();
    xfer(8'h81, 8, 1'b0, mi, lat);
    cs_end();
    chk("t4_abort_total", n_abort - base, 1);
    chk("t4_rx_level", rx_level, 1);
    chk("t4_rx_data", rx_data, 8'h81);
    drain_rx();

    // 5: back-to-back bytes from a preloaded TX FIFO
    push_tx(8'h11);
    push_tx(8'h22);
    push_tx(8'h33);
    chk("t5_tx_level", tx_level, 3);
    cs_start();
    xfer(8'hC1, 8, 1'b0, mi, lat);
    xfer(8'hC2, 8, 1'b0, mi2, lat);
    xfer(8'hC3, 8, 1'b0, mi3, lat);
    chk("t5_host_rx0", mi, 8'h11);
    chk("t5_host_rx1", mi2, 8'h22);
    chk("t5_host_rx2", mi3, 8'h33);
    chk("t5_tx_level_end", tx_level, 0);
    cs_end();
    drain_rx();

    // 6: reset in the middle of a byte with CS held low
    cs_start();
    xfer(8'hAA, 3, 1'b0, mi, lat);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("t6_rst_cipo", cipo, 0);
    chk("t6_rst_cipo_en", cipo_en, 0);
    chk("t6_rst_tx_ready", tx_ready, 1);
    chk("t6_rst_rx_valid", rx_valid, 0);
    chk("t6_rst_levels", {tx_level, rx_level}, 0);
    chk("t6_rst_busy", busy, 0);
    chk("t6_rst_pulses", {rx_ovf, tx_ufl, f_abort}, 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    base = n_ufl;
    xfer(8'h55, 5, 1'b0, mi, lat);
    cs_end();
    chk("t6_no_push", rx_level, 0);
    chk("t6_no_load", n_ufl - base, 0);
    cs_start();
    xfer(8'h5A, 8, 1'b0, mi, lat);
    chk("t6_new_host_rx", mi, 8'hFF);
    chk("t6_new_rx_data", rx_data, 8'h5A);
    cs_end();
    chk("t6_new_rx_level", rx_level, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
